// File: rtl/johnson_phase_decoder.sv
// johnson_phase_decoder: Johnson-code phase decoder with lock tracking, revolution count and fault flagging
// Ports: clk, rst (async active-low), q (Johnson state), clr (sync clear of err_sticky / ill_cnt);
//        valid, phase, onehot (decoded q, 2-edge latency), locked, rev_cnt, fault (1-cycle pulse), err_sticky.
// Option JPD_ILLEGAL_COUNT_EN adds ill_cnt[7:0], a saturating count of cycles with an illegal registered code.
module johnson_phase_decoder #(
  parameter int WIDTH    = 4,
  parameter int PH_W     = 3,
  parameter int LOCK_CNT = 2,
  parameter int REV_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     q,
  input  logic                 clr,
  output logic                 valid,
  output logic [PH_W-1:0]      phase,
  output logic [2*WIDTH-1:0]   onehot,
  output logic                 locked,
  output logic [REV_W-1:0]     rev_cnt,
  output logic                 fault,
`ifdef JPD_ILLEGAL_COUNT_EN
  output logic [7:0]           ill_cnt,
`endif
  output logic                 err_sticky
);
  localparam int NPH = 2 * WIDTH;
  localparam int GW  = $clog2(LOCK_CNT + 1);
  typedef enum logic [1:0] {HUNT, LOCKING, LOCKED, FAULT} state_t;
  state_t            r_state;
  logic [WIDTH-1:0]  r_q;
  logic [PH_W-1:0]   r_prev;
  logic [GW-1:0]     r_good;
  logic              w_legal;
  logic [PH_W-1:0]   w_ph;
  logic [PH_W-1:0]   w_next;
  logic              w_step;
  logic              w_hold;
  logic [WIDTH-1:0]  w_ones;
  // Phases 0..WIDTH fill ones from the MSB; phases WIDTH+1.. drain them from the MSB.
  always_comb begin
    w_ones  = '1;
    w_legal = 1'b0;
    w_ph    = '0;
    for (int k = 0; k < NPH; k++)
      if (r_q == ((k <= WIDTH) ? ~(w_ones >> k) : (w_ones >> (k - WIDTH)))) begin
        w_legal = 1'b1;
        w_ph    = PH_W'(k);
      end
  end
  assign w_next = (r_prev == PH_W'(NPH - 1)) ? '0 : r_prev + 1'b1;
  assign w_step = w_legal && (w_ph == w_next);
  assign w_hold = w_legal && (w_ph == r_prev);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= HUNT;
      r_q        <= '0;
      r_prev     <= '0;
      r_good     <= '0;
      valid      <= 1'b0;
      phase      <= '0;
      onehot     <= '0;
      locked     <= 1'b0;
      rev_cnt    <= '0;
      fault      <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      r_q    <= q;
      valid  <= w_legal;
      onehot <= w_legal ? NPH'(1) << w_ph : '0;
      fault  <= 1'b0;
      if (w_legal) begin
        phase  <= w_ph;
        r_prev <= w_ph;
      end
      // Fault entry below overrides this clear, so a coincident set wins.
      if (clr) err_sticky <= 1'b0;
      case (r_state)
        HUNT:
          if (w_legal) begin
            r_state <= LOCKING;
            r_good  <= '0;
          end
        LOCKING:
          if (w_step) begin
            r_good <= r_good + 1'b1;
            if (r_good == GW'(LOCK_CNT - 1)) begin
              r_state <= LOCKED;
              locked  <= 1'b1;
            end
          end else if (!w_hold) r_state <= HUNT;
        LOCKED:
          if (w_step || w_hold) begin
            if (w_step && w_ph == '0) rev_cnt <= rev_cnt + 1'b1;
          end else begin
            r_state    <= FAULT;
            locked     <= 1'b0;
            fault      <= 1'b1;
            err_sticky <= 1'b1;
          end
        default: r_state <= HUNT;
      endcase
    end
  end
`ifdef JPD_ILLEGAL_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ill_cnt <= '0;
    else if (clr) ill_cnt <= '0;
    else if (!w_legal && ill_cnt != 8'hFF) ill_cnt <= ill_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_johnson_phase_decoder.sv
// tb_johnson_phase_decoder: directed self-checking bench for johnson_phase_decoder
module tb_johnson_phase_decoder;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] q;
  logic       clr;
  logic       valid;
  logic [2:0] phase;
  logic [7:0] onehot;
  logic       locked;
  logic [7:0] rev_cnt;
  logic       fault;
  logic       err_sticky;
`ifdef JPD_ILLEGAL_COUNT_EN
  logic [7:0] ill_cnt;
`endif
  int checks = 0;
  int errors = 0;
  logic [3:0] jc [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
  johnson_phase_decoder dut (
    .clk(clk), .rst(rst), .q(q), .clr(clr), .valid(valid), .phase(phase), .onehot(onehot),
    .locked(locked), .rev_cnt(rev_cnt), .fault(fault),
`ifdef JPD_ILLEGAL_COUNT_EN
    .ill_cnt(ill_cnt),
`endif
    .err_sticky(err_sticky)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [3:0] c);
    q = c;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b0;
    q   = 4'b0000;
    clr = 1'b0;
    #2;
    chk("rst_valid", valid, 0);
    chk("rst_phase", phase, 0);
    chk("rst_onehot", onehot, 0);
    chk("rst_locked", locked, 0);
    chk("rst_rev", rev_cnt, 0);
    chk("rst_fault", fault, 0);
    chk("rst_err", err_sticky, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(jc[i % 8]);
      if (i >= 1) begin
        chk("walk_valid", valid, 1);
        chk("walk_phase", phase, (i - 1) % 8);
        chk("walk_onehot", onehot, 32'd1 << ((i - 1) % 8));
        chk("walk_fault", fault, 0);
      end
      if (i == 1 || i == 2) chk("walk_unlocked", locked, 0);
      if (i >= 3) chk("walk_locked", locked, 1);
    end
    chk("rev_two", rev_cnt, 2);
    step(4'b0101);
    chk("pre_ill_locked", locked, 1);
    chk("pre_ill_phase", phase, 3);
    step(jc[4]);
    chk("ill_valid", valid, 0);
    chk("ill_onehot", onehot, 0);
    chk("ill_phase_hold", phase, 3);
    chk("ill_fault", fault, 1);
    chk("ill_locked", locked, 0);
    chk("ill_err", err_sticky, 1);
`ifdef JPD_ILLEGAL_COUNT_EN
    chk("ill_cnt_one", ill_cnt, 1);
`endif
    step(jc[5]);
    chk("ill_fault_end", fault, 0);
    chk("ill_next_phase", phase, 4);
    step(jc[6]);
    step(jc[7]);
    chk("relock_pending", locked, 0);
    step(jc[0]);
    chk("relock", locked, 1);
    clr = 1'b1;
    step(jc[1]);
    clr = 1'b0;
    chk("clr_err", err_sticky, 0);
    chk("rev_three", rev_cnt, 3);
`ifdef JPD_ILLEGAL_COUNT_EN
    chk("ill_cnt_clr", ill_cnt, 0);
`endif
    step(4'b1110);
    chk("jump_pre_locked", locked, 1);
    chk("jump_pre_phase", phase, 1);
    step(4'b1111);
    chk("jump_fault", fault, 1);
    chk("jump_err", err_sticky, 1);
    chk("jump_locked", locked, 0);
    chk("jump_rev", rev_cnt, 3);
    chk("jump_phase", phase, 3);
    step(4'b0111);
    chk("jump_fault_end", fault, 0);
    step(jc[6]);
    step(jc[7]);
    step(jc[0]);
    chk("jump_relock", locked, 1);
    step(jc[1]);
    chk("rev_four", rev_cnt, 4);
    step(jc[2]);
    step(jc[3]);
    step(4'b1111);
    for (int i = 0; i < 3; i++) begin
      step(i < 2 ? 4'b1111 : 4'b0111);
      chk("hold_phase", phase, 4);
      chk("hold_locked", locked, 1);
      chk("hold_fault", fault, 0);
    end
    step(4'b0011);
    chk("hold_resume", phase, 5);
    chk("hold_resume_locked", locked, 1);
    chk("hold_resume_fault", fault, 0);
    clr = 1'b1;
    step(4'b0001);
    clr = 1'b0;
    chk("clr_again", err_sticky, 0);
    step(4'b0101);
    chk("pre_coincide_locked", locked, 1);
    clr = 1'b1;
    step(4'b0000);
    clr = 1'b0;
    chk("coincide_err", err_sticky, 1);
    chk("coincide_fault", fault, 1);
    step(jc[1]);
    step(jc[2]);
    step(jc[3]);
    step(jc[4]);
    chk("final_lock", locked, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_valid", valid, 0);
    chk("async_phase", phase, 0);
    chk("async_onehot", onehot, 0);
    chk("async_locked", locked, 0);
    chk("async_rev", rev_cnt, 0);
    chk("async_fault", fault, 0);
    chk("async_err", err_sticky, 0);
`ifdef JPD_ILLEGAL_COUNT_EN
    chk("async_ill", ill_cnt, 0);
`endif
    step(4'b0101);
    @(negedge clk);
    rst = 1'b1;
    step(4'b0101);
    chk("release_locked", locked, 0);
    chk("release_fault", fault, 0);
    chk("release_err", err_sticky, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
